// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register address, data word and FIFO entry.
// Imported by the arbiter, its FIFO and the bus interface.
package wb_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and memory result handshakes, regfile write port,
// and the hazard outputs seen by issue logic.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic        alu_valid;
  logic        alu_ready;
  reg_addr_t   alu_rd;
  xlen_t       alu_data;
  logic        mem_valid;
  logic        mem_ready;
  reg_addr_t   mem_rd;
  xlen_t       mem_data;
  logic        w_enable;
  reg_addr_t   w_addr;
  xlen_t       w_data;
  logic [31:0] pending;
  logic        waw_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output w_enable, w_addr, w_data,
    output pending, waw_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  w_enable, w_addr, w_data,
    input  pending, waw_err
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Memory-result FIFO; per-slot valid bits double as occupancy
// and let the arbiter build the pending mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_entry_t  push_entry,
  input  logic       pop,
  output wb_entry_t  head,
  output logic       full,
  output logic       empty,
  output reg_addr_t  entry_rd [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];

  assign full  = &valid_q;
  assign empty = ~|valid_q;
  assign head  = mem_q[rd_ptr_q];
  assign valid = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem_q[i].rd;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    if (pop && !empty) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority over buffered memory
// results until the starve counter forces a FIFO drain.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic             fifo_full, fifo_empty;
  logic             fifo_pop, alu_gnt, force_drain;
  wb_entry_t        fifo_head, push_entry, win;
  reg_addr_t        entry_rd [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [31:0]      pending;

  logic [SW-1:0] starve_q, starve_d;
  logic          w_enable_q, w_enable_d;
  reg_addr_t     w_addr_q, w_addr_d;
  xlen_t         w_data_q, w_data_d;
  logic          waw_q, waw_d;

  assign push_entry = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.mem_valid),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_rd   (entry_rd),
    .valid      (entry_vld)
  );

  always_comb begin
    force_drain = !fifo_empty && (starve_q == SW'(STARVE_MAX));
    alu_gnt     = bus.alu_valid && !force_drain;
    fifo_pop    = !alu_gnt && !fifo_empty;
  end

  assign bus.alu_ready = !force_drain;
  assign bus.mem_ready = !fifo_full;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (alu_gnt && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // x0 results are consumed but never strobe the regfile.
  always_comb begin
    win        = alu_gnt ? '{rd: bus.alu_rd, data: bus.alu_data}
                         : fifo_head;
    w_enable_d = (alu_gnt || fifo_pop) && (win.rd != '0);
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    if (w_enable_d) begin
      w_addr_d = win.rd;
      w_data_d = win.data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && entry_rd[i] != '0) begin
        pending[entry_rd[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    waw_d = waw_q;
    if (alu_gnt && bus.alu_rd != '0 && pending[bus.alu_rd]) begin
      waw_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      waw_q      <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      w_enable_q <= w_enable_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      waw_q      <= waw_d;
    end
  end

  assign bus.w_enable = w_enable_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.pending  = pending;
  assign bus.waw_err  = waw_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues drive the handshakes,
// a forked monitor pops hand-ordered expected writes as they appear.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  typedef struct {
    reg_addr_t rd;
    xlen_t     data;
  } item_t;

  logic clk = 1'b0;
  logic rst;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  item_t alu_q[$];
  item_t mem_q[$];
  item_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  function automatic item_t mk(input reg_addr_t rd, input xlen_t d);
    item_t t;
    t.rd   = rd;
    t.data = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic drive();
    bus.alu_valid = (alu_q.size() != 0);
    bus.alu_rd    = bus.alu_valid ? alu_q[0].rd : '0;
    bus.alu_data  = bus.alu_valid ? alu_q[0].data : '0;
    bus.mem_valid = (mem_q.size() != 0);
    bus.mem_rd    = bus.mem_valid ? mem_q[0].rd : '0;
    bus.mem_data  = bus.mem_valid ? mem_q[0].data : '0;
  endtask

  task automatic step();
    logic a, m;
    @(negedge clk);
    a = bus.alu_valid && bus.alu_ready;
    m = bus.mem_valid && bus.mem_ready;
    @(posedge clk);
    #1;
    if (a) void'(alu_q.pop_front());
    if (m) void'(mem_q.pop_front());
    drive();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    item_t e;
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_enable", 64'(bus.w_enable), 64'h0);
    chk("rst_w_addr", 64'(bus.w_addr), 64'h0);
    chk("rst_w_data", 64'(bus.w_data), 64'h0);
    chk("rst_pending", 64'(bus.pending), 64'h0);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'h1);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'h1);
    chk("rst_waw_err", 64'(bus.waw_err), 64'h0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (bus.w_enable === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got rd=%0d data=%h required no write",
                     bus.w_addr, bus.w_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_write", {27'b0, bus.w_addr, bus.w_data},
                {27'b0, e.rd, e.data});
          end
        end
      end
    join_none

    // ALU only: one-cycle latency
    alu_q.push_back(mk(5'd5, 32'hDEADBEEF));
    exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
    drive();
    chk("s1_alu_ready", 64'(bus.alu_ready), 64'h1);
    step();
    chk("s1_w_enable", 64'(bus.w_enable), 64'h1);
    chk("s1_w_addr", 64'(bus.w_addr), 64'h5);
    steps(2);

    // Memory only: pending then write two cycles later
    mem_q.push_back(mk(5'd7, 32'h1234));
    exp_q.push_back(mk(5'd7, 32'h1234));
    drive();
    chk("s2_pending_pre", 64'(bus.pending), 64'h0);
    step();
    chk("s2_pending_set", 64'(bus.pending[7]), 64'h1);
    chk("s2_no_bypass", 64'(bus.w_enable), 64'h0);
    step();
    chk("s2_w_enable", 64'(bus.w_enable), 64'h1);
    chk("s2_pending_clr", 64'(bus.pending[7]), 64'h0);
    steps(2);

    // Starvation: one buffered entry against a stream of ALU results
    mem_q.push_back(mk(5'd3, 32'h33));
    for (int i = 0; i < 6; i++) begin
      alu_q.push_back(mk(reg_addr_t'(10 + i), 32'hA000_0000 + i));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(alu_q[i]);
    exp_q.push_back(mk(5'd3, 32'h33));
    exp_q.push_back(alu_q[4]);
    exp_q.push_back(alu_q[5]);
    drive();
    steps(4);
    chk("s3_forced_drain", 64'(bus.alu_ready), 64'h0);
    steps(6);
    chk("s3_alu_resumed", 64'(bus.alu_ready), 64'h1);

    // Full FIFO with ALU always valid
    for (int i = 0; i < 5; i++) begin
      mem_q.push_back(mk(reg_addr_t'(16 + i), 32'h100 + i));
    end
    for (int i = 0; i < 10; i++) begin
      alu_q.push_back(mk(reg_addr_t'(21 + i), 32'hB000_0000 + i));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(alu_q[i]);
    exp_q.push_back(mem_q[0]);
    for (int i = 4; i < 7; i++) exp_q.push_back(alu_q[i]);
    exp_q.push_back(mem_q[1]);
    for (int i = 7; i < 10; i++) exp_q.push_back(alu_q[i]);
    for (int i = 2; i < 5; i++) exp_q.push_back(mem_q[i]);
    drive();
    steps(4);
    chk("s4_full_mem_ready", 64'(bus.mem_ready), 64'h0);
    chk("s4_full_alu_ready", 64'(bus.alu_ready), 64'h0);
    step();
    chk("s4_after_pop_ready", 64'(bus.mem_ready), 64'h1);
    step();
    chk("s4_pending", 64'(bus.pending), 64'h001E_0000);
    steps(12);
    chk("s4_waw_clear", 64'(bus.waw_err), 64'h0);

    // x0 results are consumed silently
    alu_q.push_back(mk(5'd0, 32'hBAD));
    mem_q.push_back(mk(5'd0, 32'hBAD2));
    drive();
    step();
    chk("s5_pending", 64'(bus.pending), 64'h0);
    chk("s5_alu_x0", 64'(bus.w_enable), 64'h0);
    step();
    chk("s5_mem_x0", 64'(bus.w_enable), 64'h0);
    chk("s5_drained", 64'(bus.mem_ready), 64'h1);
    steps(2);

    // Reset mid-operation
    mem_q.push_back(mk(5'd1, 32'h11));
    mem_q.push_back(mk(5'd2, 32'h22));
    alu_q.push_back(mk(5'd4, 32'hC0));
    alu_q.push_back(mk(5'd6, 32'hC1));
    alu_q.push_back(mk(5'd8, 32'hC2));
    exp_q.push_back(mk(5'd4, 32'hC0));
    exp_q.push_back(mk(5'd6, 32'hC1));
    drive();
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_w_enable", 64'(bus.w_enable), 64'h0);
    chk("s6_pending", 64'(bus.pending), 64'h0);
    chk("s6_mem_ready", 64'(bus.mem_ready), 64'h1);
    chk("s6_waw_err", 64'(bus.waw_err), 64'h0);

    // WAW injection after reset
    mem_q.push_back(mk(5'd9, 32'h99));
    exp_q.push_back(mk(5'd9, 32'h999));
    exp_q.push_back(mk(5'd9, 32'h99));
    drive();
    step();
    alu_q.push_back(mk(5'd9, 32'h999));
    drive();
    chk("s6_pending9", 64'(bus.pending), 64'h0000_0200);
    step();
    chk("s6_waw_set", 64'(bus.waw_err), 64'h1);
    steps(4);
    chk("s6_waw_sticky", 64'(bus.waw_err), 64'h1);

    chk("sb_all_written", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
